// File: rtl/modinv_255bit.sv
// Sequential modular inverter over GF(2^255 - 19): binary extended Euclid, one update per clock.
// Optional MODINV_CONST_TIME_EN pads every operation to a fixed MAX_ITER-step run.
module modinv_255bit #(
  parameter int MAX_ITER = 1020
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] in,
  output logic [254:0] out,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;
  localparam int CW = $clog2(MAX_ITER + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  state_t        state, state_n;
  logic [254:0]  u_raw;
  logic [255:0]  u, v, x1, x2;
  logic [CW-1:0] cnt;
  logic          have_res, res_err;
  logic [254:0]  res;

  logic [255:0]  u_red;
  logic          cur_term, cur_err, at_max;
  logic [254:0]  cur_res;
  logic          fin_load, fin_err, do_update, do_latch;
  logic [254:0]  fin_res;

  // Halving mod p: odd values get p added first so the shift stays exact.
  function automatic logic [255:0] half_mod(input logic [255:0] x);
    logic [255:0] s;
    s = x[0] ? x + P : x;
    return s >> 1;
  endfunction

  function automatic logic [255:0] sub_mod(input logic [255:0] a, input logic [255:0] b);
    return (a >= b) ? a - b : a - b + P;
  endfunction

  function automatic logic [254:0] reduce(input logic [255:0] x);
    logic [255:0] d;
    d = x - P;
    return (x >= P) ? d[254:0] : x[254:0];
  endfunction

  always_comb begin
    u_red    = {1'b0, reduce({1'b0, u_raw})};
    at_max   = (cnt == CW'(MAX_ITER));
    cur_term = have_res || (u == 256'd1) || (v == 256'd1);
    cur_err  = have_res && res_err;
    if (have_res)
      cur_res = res;
    else if (u == 256'd1)
      cur_res = reduce(x1);
    else
      cur_res = reduce(x2);
  end

  always_comb begin
    state_n   = state;
    fin_load  = 1'b0;
    fin_res   = '0;
    fin_err   = 1'b0;
    do_update = 1'b0;
    do_latch  = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = LOAD;
      LOAD: begin
`ifdef MODINV_CONST_TIME_EN
        state_n = RUN;
`else
        if (u_red == '0) begin
          state_n  = FIN;
          fin_load = 1'b1;
          fin_err  = 1'b1;
        end else begin
          state_n = RUN;
        end
`endif
      end
      RUN: begin
`ifdef MODINV_CONST_TIME_EN
        // Once a result is latched the datapath freezes and only the counter runs.
        if (at_max) begin
          state_n  = FIN;
          fin_load = 1'b1;
          fin_res  = cur_term ? cur_res : '0;
          fin_err  = cur_term ? cur_err : 1'b1;
        end else if (cur_term) begin
          do_latch = 1'b1;
        end else begin
          do_update = 1'b1;
        end
`else
        if (cur_term) begin
          state_n  = FIN;
          fin_load = 1'b1;
          fin_res  = cur_res;
          fin_err  = cur_err;
        end else if (at_max) begin
          state_n  = FIN;
          fin_load = 1'b1;
          fin_err  = 1'b1;
        end else begin
          do_update = 1'b1;
        end
`endif
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u_raw    <= '0;
      u        <= '0;
      v        <= '0;
      x1       <= '0;
      x2       <= '0;
      cnt      <= '0;
      have_res <= 1'b0;
      res      <= '0;
      res_err  <= 1'b0;
      out      <= '0;
      err      <= 1'b0;
    end else begin
      if (state == IDLE && start) u_raw <= in;
      if (state == LOAD) begin
        u        <= u_red;
        v        <= P;
        x1       <= 256'd1;
        x2       <= '0;
        cnt      <= '0;
        have_res <= 1'b0;
        res      <= '0;
        res_err  <= 1'b0;
`ifdef MODINV_CONST_TIME_EN
        if (u_red == '0) begin
          have_res <= 1'b1;
          res_err  <= 1'b1;
        end
`endif
      end
      if (do_latch) begin
        have_res <= 1'b1;
        res      <= cur_res;
        res_err  <= cur_err;
        cnt      <= cnt + 1'b1;
      end
      // Invariant kept: x1*a == u and x2*a == v (mod p) after every update.
      if (do_update) begin
        cnt <= cnt + 1'b1;
        if (!u[0]) begin
          u  <= u >> 1;
          x1 <= half_mod(x1);
        end else if (!v[0]) begin
          v  <= v >> 1;
          x2 <= half_mod(x2);
        end else if (u >= v) begin
          u  <= u - v;
          x1 <= sub_mod(x1, x2);
        end else begin
          v  <= v - u;
          x2 <= sub_mod(x2, x1);
        end
      end
      if (fin_load) begin
        out <= fin_res;
        err <= fin_err;
      end
    end
  end

  assign done = (state == FIN);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_modinv_255bit.sv
// Self-checking bench for modinv_255bit: directed corner cases plus random operands
// checked against a Fermat-exponentiation reference (a^(p-2) mod p).
module tb_modinv_255bit;

  localparam int MAX_ITER = 1020;
  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;
`ifdef MODINV_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif
  localparam int LAT_OK  = CONST_TIME ? 3 + MAX_ITER : 3;
  localparam int LAT_ERR = CONST_TIME ? 3 + MAX_ITER : 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [254:0] in_val;
  logic [254:0] out_val;
  logic         done, busy, err;

  int checks      = 0;
  int miscompares = 0;

  modinv_255bit #(.MAX_ITER(MAX_ITER)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in   (in_val),
    .out  (out_val),
    .done (done),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  function automatic logic [254:0] mod_mul(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] t;
    t = 512'(a) * 512'(b);
    t = t % 512'(P);
    return t[254:0];
  endfunction

  function automatic logic [254:0] ref_inv(input logic [254:0] a);
    logic [255:0] e, b256;
    logic [254:0] r, base;
    e    = P - 256'd2;
    b256 = 256'(a) % P;
    base = b256[254:0];
    r    = 255'd1;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mod_mul(r, base);
      base = mod_mul(base, base);
    end
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits one idle cycle, issues a single start, then waits (bounded) for done.
  task automatic apply_stimulus(input logic [254:0] a, output int lat, output logic [254:0] r,
                                output logic e, output bit timed_out);
    @(posedge clk); #1;
    in_val = a;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    in_val = '0;
    timed_out = 1'b1;
    lat = 0;
    r   = '0;
    e   = 1'b0;
    for (int i = 1; i <= MAX_ITER + 16; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i + 1;
        r   = out_val;
        e   = err;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int           lat, dones;
    logic [254:0] r, a, exp_v;
    logic [255:0] tmp;
    logic         e;
    bit           to, lat_ok;

    rst = 1'b1; start = 1'b0; in_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_out",  256'(out_val), 256'd0);
    check_output("reset_done", 256'(done),    256'd0);
    check_output("reset_busy", 256'(busy),    256'd0);
    check_output("reset_err",  256'(err),     256'd0);
    rst = 1'b0;

    // a = 1, also checks busy rises in the LOAD cycle
    @(posedge clk); #1;
    in_val = 255'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("busy_in_load", 256'(busy), 256'd1);
    to = 1'b1; lat = 0;
    for (int i = 1; i <= MAX_ITER + 16; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i + 1; to = 1'b0; break; end
    end
    check_output("one_timeout", 256'(to), 256'd0);
    check_output("one_out", 256'(out_val), 256'd1);
    check_output("one_err", 256'(err), 256'd0);
    check_output("one_latency", 256'(lat), 256'(LAT_OK));

    // a = 2 -> (p+1)/2
    apply_stimulus(255'd2, lat, r, e, to);
    tmp = (P + 256'd1) >> 1;
    check_output("two_out", 256'(r), tmp);
    check_output("two_ref", 256'(r), 256'(ref_inv(255'd2)));
    check_output("two_product", 256'(mod_mul(255'd2, r)), 256'd1);
    @(posedge clk); #1;
    check_output("two_done_pulse", 256'(done), 256'd0);
    check_output("two_out_held", 256'(out_val), tmp);

    // p - 1 is its own inverse
    tmp = P - 256'd1;
    apply_stimulus(tmp[254:0], lat, r, e, to);
    check_output("pm1_out", 256'(r), tmp);
    check_output("pm1_err", 256'(e), 256'd0);

    // p + 1 reduces to 1
    tmp = P + 256'd1;
    apply_stimulus(tmp[254:0], lat, r, e, to);
    check_output("pp1_out", 256'(r), 256'd1);
    check_output("pp1_err", 256'(e), 256'd0);

    // zero operands
    apply_stimulus(255'd0, lat, r, e, to);
    check_output("zero_err", 256'(e), 256'd1);
    check_output("zero_out", 256'(r), 256'd0);
    check_output("zero_latency", 256'(lat), 256'(LAT_ERR));
    apply_stimulus(P[254:0], lat, r, e, to);
    check_output("p_err", 256'(e), 256'd1);
    check_output("p_out", 256'(r), 256'd0);
    check_output("p_latency", 256'(lat), 256'(LAT_ERR));

    // random operands in [1, p-1]
    for (int n = 0; n < 30; n++) begin
      do begin
        tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        tmp[255] = 1'b0;
      end while (tmp == 256'd0 || tmp >= P);
      a = tmp[254:0];
      apply_stimulus(a, lat, r, e, to);
      exp_v = ref_inv(a);
      check_output("rand_timeout", 256'(to), 256'd0);
      check_output("rand_err", 256'(e), 256'd0);
      check_output("rand_out", 256'(r), 256'(exp_v));
      check_output("rand_product", 256'(mod_mul(a, r)), 256'd1);
      lat_ok = CONST_TIME ? (lat == 3 + MAX_ITER) : (lat >= 3 && lat <= 3 + MAX_ITER);
      check_output("rand_latency", 256'(lat_ok), 256'd1);
    end

    // abort: 2^254 needs 254 halvings, so a reset 200 cycles in lands mid-run
    @(posedge clk); #1;
    in_val = 255'd1 << 254; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    repeat (199) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check_output("busy_before_abort", 256'(busy), 256'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_output("abort_out",  256'(out_val), 256'd0);
    check_output("abort_done", 256'(done),    256'd0);
    check_output("abort_busy", 256'(busy),    256'd0);
    check_output("abort_err",  256'(err),     256'd0);
    repeat (MAX_ITER + 16) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check_output("abort_no_done", 256'(dones), 256'd0);

    // operation after abort: inverse of 3 is (2p+1)/3
    apply_stimulus(255'd3, lat, r, e, to);
    tmp = (2 * P + 256'd1) / 256'd3;
    check_output("three_out", 256'(r), tmp);
    check_output("three_err", 256'(e), 256'd0);

    // start held high throughout: exactly one completion
    @(posedge clk); #1;
    in_val = 255'd5; start = 1'b1;
    dones = 0; r = '0;
    for (int i = 0; i <= MAX_ITER + 16; i++) begin
      @(posedge clk); #1;
      if (done) begin dones++; r = out_val; start = 1'b0; break; end
    end
    start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check_output("held_start_dones", 256'(dones), 256'd1);
    check_output("held_start_out", 256'(r), 256'(ref_inv(255'd5)));
    check_output("held_start_idle", 256'(busy), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
    $finish;
  end

endmodule
